// File: rtl/program_loader.sv
// program_loader: streams a length byte, payload bytes and (with PROGRAM_LOADER_CHECKSUM_EN) a checksum byte into processor memory, then raises op.
// Latency: one write strobe a cycle after each accepted payload byte; op two cycles after the last payload byte, or one cycle after the checksum.
// Backpressure: s_ready is high only in LEN/DATA/CHK and never drops mid-load; host stalls hold state and produce no strobe.
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       user_write_memory,
  output logic [7:0] user_address,
  output logic [7:0] in_data,
  output logic       op,
  output logic       busy,
  output logic       error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, RUN, ERR} state_t;
  logic [7:0] sum;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, RUN} state_t;
  assign error = 1'b0;
`endif

  state_t     state;
  logic [7:0] addr;
  // 9 bits so a length byte of 0 can stand for 256 payload bytes
  logic [8:0] remaining;
  logic       xfer;

  assign xfer = s_valid && s_ready;

  // Load sequencer: all outputs are registered and updated together with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      s_ready           <= 1'b0;
      busy              <= 1'b0;
      op                <= 1'b0;
      user_write_memory <= 1'b0;
      user_address      <= BASE_ADDR;
      in_data           <= 8'h00;
      addr              <= BASE_ADDR;
      remaining         <= 9'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum               <= 8'h00;
      error             <= 1'b0;
`endif
    end else begin
      // strobe is a single-cycle pulse unless a payload byte lands this cycle
      user_write_memory <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= LEN;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LEN: begin
          if (xfer) begin
            remaining <= {s_data == 8'd0, s_data};
            addr      <= BASE_ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum       <= 8'h00;
`endif
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            user_write_memory <= 1'b1;
            user_address      <= addr;
            in_data           <= s_data;
            addr              <= addr + 8'd1;
            remaining         <= remaining - 9'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum               <= sum + s_data;
            if (remaining == 9'd1) begin
              state <= CHK;
            end
`else
            // op is raised one cycle later, in RUN, so it never overlaps the last strobe
            if (remaining == 9'd1) begin
              state   <= RUN;
              s_ready <= 1'b0;
              busy    <= 1'b0;
            end
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == sum) begin
              state <= RUN;
              op    <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        ERR: begin
          if (abort) begin
            error <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            error   <= 1'b0;
            state   <= LEN;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
`endif
        RUN: begin
          if (abort) begin
            op    <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            op      <= 1'b0;
            state   <= LEN;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end else begin
            op <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
          op      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: randomized byte streams, a queue of expected memory
// writes filled by the driver and drained by a strobe monitor, plus state/timing checks.
module tb_program_loader;
  localparam logic [7:0] BASE = 8'hFE;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       user_write_memory;
  logic [7:0] user_address;
  logic [7:0] in_data;
  logic       op;
  logic       busy;
  logic       error;

  program_loader #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .user_write_memory(user_write_memory),
    .user_address(user_address),
    .in_data(in_data),
    .op(op),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem[256];
  logic [7:0] pay[$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  bit         bad_ck = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe must match the oldest expected write, in the expected cycle
  always @(negedge clk) begin : monitor
    wr_t got;
    wr_t want;
    if (user_write_memory === 1'b1) begin
      got = {user_address, in_data, 32'(cyc)};
      mem[user_address] = in_data;
      chk("wr_op_low", {63'd0, op}, 64'd0);
      chk("wr_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("wr", {16'd0, got}, {16'd0, want});
      end
    end
  end

  // One byte over the handshake; payload bytes queue an expected write at BASE+idx
  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit payload,
                           input logic [7:0] idx, output int xcyc);
    int waited;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      s_valid = 1'b0;
      case ($urandom_range(5))
        0: start = 1'b1;
        1: abort = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      chk("stall_rdy", {63'd0, s_ready}, 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = b;
    waited  = 0;
    xcyc    = -1;
    while (xcyc < 0) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        xcyc = cyc;
        if (payload) exp_q.push_back({BASE + idx, b, 32'(cyc + 1)});
      end else begin
        waited++;
        if (waited > 8) begin
          chk("rdy_timeout", {63'd0, s_ready}, 64'd1);
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Full load of the bytes in pay; ends in a negedge after op/error has settled
  task automatic do_load(input int gap_pct);
    int n;
    int xcyc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] ck;
    ck = 8'h00;
    foreach (pay[i]) ck = ck + pay[i];
`endif
    n = pay.size();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_rdy", {63'd0, s_ready}, 64'd1);
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_op", {63'd0, op}, 64'd0);
    chk("start_err", {63'd0, error}, 64'd0);
    @(posedge clk);
    #1;
    send_byte(n[7:0], 0, 1'b0, 8'd0, xcyc);
    for (int i = 0; i < n; i++) send_byte(pay[i], gap_pct, 1'b1, i[7:0], xcyc);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_ck ? ck + 8'd1 : ck, gap_pct, 1'b0, 8'd0, xcyc);
    @(negedge clk);
    chk("ck_op", {63'd0, op}, {63'd0, !bad_ck});
    chk("ck_err", {63'd0, error}, {63'd0, bad_ck});
    chk("end_rdy", {63'd0, s_ready}, 64'd0);
    chk("end_busy", {63'd0, busy}, 64'd0);
`else
    @(negedge clk);
    chk("op_early", {63'd0, op}, 64'd0);
    @(negedge clk);
    chk("op_rise", {63'd0, op}, 64'd1);
    chk("end_rdy", {63'd0, s_ready}, 64'd0);
    chk("end_busy", {63'd0, busy}, 64'd0);
    chk("end_err", {63'd0, error}, 64'd0);
`endif
    chk("load_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},  {63'd0, s_ready}, 64'd0);
    chk({tag, "_wr"},   {63'd0, user_write_memory}, 64'd0);
    chk({tag, "_addr"}, {56'd0, user_address}, {56'd0, BASE});
    chk({tag, "_data"}, {56'd0, in_data}, 64'd0);
    chk({tag, "_op"},   {63'd0, op}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_err"},  {63'd0, error}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int xcyc;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rdy", {63'd0, s_ready}, 64'd0);

    // Basic stream, addresses FE, FF, 00 exercise the wrap
    pay = {8'hAA, 8'hBB, 8'hCC};
    do_load(0);
    pay = {8'h01, 8'h02, 8'h03};
    do_load(0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Wrong checksum lands in ERR; a following good load recovers
    bad_ck = 1'b1;
    pay = {8'h10, 8'h20};
    do_load(0);
    @(negedge clk);
    chk("err_hold_op", {63'd0, op}, 64'd0);
    chk("err_hold", {63'd0, error}, 64'd1);
    bad_ck = 1'b0;
    pay = {8'h10, 8'h20};
    do_load(0);
`endif

    // Length 0 means 256 bytes covering every address
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(i[7:0]);
    do_load(0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = BASE + i[7:0];
      if (mem[a] !== i[7:0]) chk("mem256", {56'd0, mem[a]}, {56'd0, i[7:0]});
    end

    // Random payloads with host stalls and ignored start/abort pulses
    repeat (6) begin
      pay.delete();
      n = $urandom_range(1, 24);
      repeat (n) pay.push_back(8'($urandom));
      do_load(35);
    end

    // start and abort together in RUN: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("sa_op", {63'd0, op}, 64'd0);
    chk("sa_rdy", {63'd0, s_ready}, 64'd0);
    chk("sa_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("sa_idle", {63'd0, s_ready}, 64'd0);

    // Reset after two of four payload bytes have been written
    mem[BASE] = 8'h00;
    mem[BASE + 8'd1] = 8'h00;
    pay = {8'h5A, 8'hC3, 8'h77, 8'h99};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'd4, 0, 1'b0, 8'd0, xcyc);
    send_byte(pay[0], 0, 1'b1, 8'd0, xcyc);
    send_byte(pay[1], 0, 1'b1, 8'd1, xcyc);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("keep0", {56'd0, mem[BASE]}, {56'd0, pay[0]});
    chk("keep1", {56'd0, mem[BASE + 8'd1]}, {56'd0, pay[1]});
    repeat (3) @(negedge clk);
    chk("post_rst_rdy", {63'd0, s_ready}, 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
